// File: rtl/lsu_mc.sv
// Multi-cycle load-store unit: data memory over a req/ack bus with timeout,
// a byte-writable output-register bank and two read-only input words.
module lsu_mc #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DMEM_BYTES = 32'h2000,
   parameter int unsigned OUT_BASE   = 32'h7000,
   parameter int unsigned NUM_OUT    = 8,
   parameter int unsigned IN_BASE    = 32'h7800,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_req,
   input  logic                    i_wren,
   input  logic [ADDR_W-1:0]       i_addr,
   input  logic [31:0]             i_st_data,
   input  logic [2:0]              i_l_sel,
   input  logic [1:0]              i_s_sel,
   input  logic [31:0]             i_io_sw,
   input  logic [3:0]              i_io_btn,
   input  logic [31:0]             i_mem_rdata,
   input  logic                    i_mem_ack,
   output logic                    o_busy,
   output logic                    o_ack,
   output logic [31:0]             o_ld_data,
   output logic                    o_err,
   output logic [1:0]              o_err_code,
   output logic [ADDR_W-1:0]       o_mem_addr,
   output logic [31:0]             o_mem_wdata,
   output logic [3:0]              o_mem_be,
   output logic                    o_mem_wren,
   output logic                    o_mem_rden,
   output logic [32*NUM_OUT-1:0]   o_io_out
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);
   localparam int unsigned IdxW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

   localparam logic [CntW-1:0]   CntLast = CntW'(TIMEOUT - 1);
   localparam logic [ADDR_W-1:0] DmemEnd = ADDR_W'(DMEM_BYTES);
   localparam logic [ADDR_W-1:0] OutLo   = ADDR_W'(OUT_BASE);
   localparam logic [ADDR_W-1:0] OutHi   = ADDR_W'(OUT_BASE + 4 * NUM_OUT);
   localparam logic [ADDR_W-1:0] InLo    = ADDR_W'(IN_BASE);
   localparam logic [ADDR_W-1:0] InHi    = ADDR_W'(IN_BASE + 8);

   localparam logic [1:0] ErrNone = 2'b00;
   localparam logic [1:0] ErrMis  = 2'b01;
   localparam logic [1:0] ErrMap  = 2'b10;
   localparam logic [1:0] ErrTmo  = 2'b11;

   typedef enum logic [1:0] {StIdle, StMem, StResp} state_e;

   state_e state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [3:0]        be_q;
   logic              wren_q;
   logic [2:0]        l_sel_q;
   logic              err_q;
   logic [1:0]        code_q;
   logic [31:0]       ld_data_q;
   logic [31:0]       out_q [NUM_OUT];

   // Request decode
   logic            ld_byte, ld_half, misaligned, illegal, unmapped;
   logic            in_out, in_in, in_dmem, in_hi, to_io, accept, out_wr;
   logic [1:0]      acc_code;
   logic [3:0]      st_be;
   logic [31:0]     st_wdata, io_word;
   logic [IdxW-1:0] out_idx;

   // Sign/zero-extend a byte or half-word picked out of a 32-bit word.
   function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] off,
                                            input logic [2:0] sel);
      logic [7:0]  b;
      logic [15:0] h;
      b = 8'(w >> {off, 3'b000});
      h = off[1] ? w[31:16] : w[15:0];
      case (sel)
         3'b001:  return {{24{b[7]}}, b};
         3'b010:  return {{16{h[15]}}, h};
         3'b011:  return {24'b0, b};
         3'b100:  return {16'b0, h};
         default: return w;
      endcase
   endfunction

   // Classify the incoming request and build its lane-replicated store data.
   always_comb begin
      ld_byte  = (i_l_sel == 3'b001) || (i_l_sel == 3'b011);
      ld_half  = (i_l_sel == 3'b010) || (i_l_sel == 3'b100);
      in_out   = (i_addr >= OutLo) && (i_addr < OutHi);
      in_in    = (i_addr >= InLo) && (i_addr < InHi);
      in_dmem  = (i_addr < DmemEnd);
      in_hi    = ((i_addr - InLo) & ADDR_W'(4)) != '0;
      out_idx  = IdxW'((i_addr - OutLo) >> 2);
      to_io    = in_out || in_in;

      if (i_wren) begin
         misaligned = ((i_s_sel == 2'b10) && i_addr[0]) ||
                      ((i_s_sel == 2'b11) && (i_addr[1:0] != 2'b00));
      end else begin
         misaligned = ld_half ? i_addr[0] : (!ld_byte && (i_addr[1:0] != 2'b00));
      end
      illegal  = i_wren && (i_s_sel == 2'b00);
      // The input window is read-only, so a store there counts as unmapped.
      unmapped = !(to_io || in_dmem) || (i_wren && in_in);

      acc_code = ErrNone;
      if (misaligned) begin
         acc_code = ErrMis;
      end else if (illegal || unmapped) begin
         acc_code = ErrMap;
      end

      st_be    = 4'b1111;
      st_wdata = i_st_data;
      if (i_wren) begin
         case (i_s_sel)
            2'b01: begin
               st_be    = 4'b0001 << i_addr[1:0];
               st_wdata = {4{i_st_data[7:0]}};
            end
            2'b10: begin
               st_be    = i_addr[1] ? 4'b1100 : 4'b0011;
               st_wdata = {2{i_st_data[15:0]}};
            end
            default: ;
         endcase
      end

      io_word  = in_out ? out_q[out_idx] : (in_hi ? {28'b0, i_io_btn} : i_io_sw);
      accept   = (state_q == StIdle) && i_req;
      out_wr   = accept && (acc_code == ErrNone) && in_out && i_wren;
   end

   // Next-state and timeout counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      unique case (state_q)
         StIdle: begin
            if (i_req) begin
               state_d = ((acc_code == ErrNone) && !to_io) ? StMem : StResp;
            end
         end
         StMem: begin
            if (i_mem_ack || (cnt_q == CntLast)) begin
               state_d = StResp;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State register; reset also aborts an in-flight memory access.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Request latches, error status and load result.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         wren_q    <= 1'b0;
         l_sel_q   <= '0;
         err_q     <= 1'b0;
         code_q    <= ErrNone;
         ld_data_q <= '0;
      end else begin
         if (accept) begin
            addr_q  <= i_addr;
            wdata_q <= st_wdata;
            be_q    <= st_be;
            wren_q  <= i_wren;
            l_sel_q <= i_l_sel;
            err_q   <= (acc_code != ErrNone);
            code_q  <= acc_code;
            if ((acc_code == ErrNone) && to_io && !i_wren) begin
               ld_data_q <= fmt_load(io_word, i_addr[1:0], i_l_sel);
            end
         end
         if (state_q == StMem) begin
            if (i_mem_ack) begin
               if (!wren_q) begin
                  ld_data_q <= fmt_load(i_mem_rdata, addr_q[1:0], l_sel_q);
               end
            end else if (cnt_q == CntLast) begin
               err_q  <= 1'b1;
               code_q <= ErrTmo;
            end
         end
      end
   end

   // Output-register bank, written byte-wise at the acceptance edge.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         for (int k = 0; k < NUM_OUT; k++) begin
            out_q[k] <= '0;
         end
      end else if (out_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (st_be[b]) begin
               out_q[out_idx][8*b +: 8] <= st_wdata[8*b +: 8];
            end
         end
      end
   end

   for (genvar k = 0; k < NUM_OUT; k++) begin : g_io_out
      assign o_io_out[32*k +: 32] = out_q[k];
   end

   // Strobes and byte enables are only driven while a memory access is open.
   always_comb begin
      o_busy      = (state_q != StIdle);
      o_ack       = (state_q == StResp);
      o_err       = o_ack && err_q;
      o_err_code  = o_ack ? code_q : ErrNone;
      o_ld_data   = ld_data_q;
      o_mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
      o_mem_wdata = wdata_q;
      o_mem_be    = (state_q == StMem) ? be_q : 4'b0000;
      o_mem_wren  = (state_q == StMem) && wren_q;
      o_mem_rden  = (state_q == StMem) && !wren_q;
   end

endmodule

// File: tb/tb_lsu_mc.sv
// Directed bench for lsu_mc: IO bank, DMEM handshake, error classes, timeout, reset abort.
module tb_lsu_mc;

   logic         clk = 1'b0;
   logic         rst;
   logic         req, wren, mem_ack;
   logic [31:0]  addr, st_data, io_sw, mem_rdata;
   logic [2:0]   l_sel;
   logic [1:0]   s_sel;
   logic [3:0]   io_btn;
   logic         busy, ack, err, mem_wren, mem_rden;
   logic [31:0]  ld_data, mem_addr, mem_wdata;
   logic [1:0]   err_code;
   logic [3:0]   mem_be;
   logic [255:0] io_out;

   int checks = 0;
   int errors = 0;
   int n_strobe;

   lsu_mc dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req       (req),
      .i_wren      (wren),
      .i_addr      (addr),
      .i_st_data   (st_data),
      .i_l_sel     (l_sel),
      .i_s_sel     (s_sel),
      .i_io_sw     (io_sw),
      .i_io_btn    (io_btn),
      .i_mem_rdata (mem_rdata),
      .i_mem_ack   (mem_ack),
      .o_busy      (busy),
      .o_ack       (ack),
      .o_ld_data   (ld_data),
      .o_err       (err),
      .o_err_code  (err_code),
      .o_mem_addr  (mem_addr),
      .o_mem_wdata (mem_wdata),
      .o_mem_be    (mem_be),
      .o_mem_wren  (mem_wren),
      .o_mem_rden  (mem_rden),
      .o_io_out    (io_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] oreg(input int k);
      return io_out[32*k +: 32];
   endfunction

   // Present one request for one cycle; returns just after the acceptance edge.
   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] ls, input logic [1:0] ss);
      wren = w; addr = a; st_data = d; l_sel = ls; s_sel = ss; req = 1'b1;
      tick();
      req = 1'b0;
   endtask

   task automatic check_resp(input string tag, input logic e, input logic [1:0] code);
      check({tag, "_ack"}, {31'b0, ack}, 32'd1);
      check({tag, "_err"}, {31'b0, err}, {31'b0, e});
      check({tag, "_code"}, {30'b0, err_code}, {30'b0, code});
   endtask

   initial begin
      rst = 1'b0; req = 1'b0; wren = 1'b0; mem_ack = 1'b0;
      addr = '0; st_data = '0; io_sw = '0; mem_rdata = '0;
      l_sel = '0; s_sel = '0; io_btn = '0;

      // Reset
      tick(); tick();
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_ack", {31'b0, ack}, 32'd0);
      check("rst_err", {30'b0, err, 1'b0} | {30'b0, err_code}, 32'd0);
      check("rst_strobes", {26'b0, mem_be, mem_wren, mem_rden}, 32'd0);
      check("rst_ld_data", ld_data, 32'd0);
      for (int k = 0; k < 8; k++) check($sformatf("rst_oreg%0d", k), oreg(k), 32'd0);
      rst = 1'b1;
      tick();

      // SB into output register 1, then signed and unsigned byte loads back
      issue(1'b1, 32'h7005, 32'h0000_00AB, 3'b000, 2'b01);
      check_resp("sb_out", 1'b0, 2'b00);
      check("sb_oreg1", oreg(1), 32'h0000_AB00);
      check("sb_no_be", {28'b0, mem_be}, 32'd0);
      check("sb_no_wren", {31'b0, mem_wren}, 32'd0);
      tick();
      check("sb_idle", {30'b0, busy, ack}, 32'd0);
      issue(1'b0, 32'h7005, 32'h0, 3'b001, 2'b00);
      check_resp("lb_out", 1'b0, 2'b00);
      check("lb_out_data", ld_data, 32'hFFFF_FFAB);
      tick();
      issue(1'b0, 32'h7005, 32'h0, 3'b011, 2'b00);
      check("lbu_out_data", ld_data, 32'h0000_00AB);
      tick();

      // LW from DMEM with three wait cycles
      issue(1'b0, 32'h0000_0100, 32'h0, 3'b000, 2'b00);
      check("lw_mem_addr", mem_addr, 32'h0000_0100);
      check("lw_mem_be", {28'b0, mem_be}, 32'hF);
      n_strobe = 0;
      for (int i = 0; i < 3; i++) begin
         if (mem_rden) n_strobe++;
         tick();
      end
      if (mem_rden) n_strobe++;
      mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
      tick();
      mem_ack = 1'b0; mem_rdata = 32'hDEAD_DEAD;
      check("lw_rden_cycles", n_strobe, 32'd4);
      check_resp("lw_mem", 1'b0, 2'b00);
      check("lw_rden_drop", {31'b0, mem_rden}, 32'd0);
      check("lw_data", ld_data, 32'h1234_5678);
      tick();

      // LH at upper half, acked in the first MEM cycle
      issue(1'b0, 32'h0000_0102, 32'h0, 3'b010, 2'b00);
      check("lh_rden", {31'b0, mem_rden}, 32'd1);
      check("lh_mem_addr", mem_addr, 32'h0000_0100);
      mem_ack = 1'b1; mem_rdata = 32'h8001_5555;
      tick();
      mem_ack = 1'b0;
      check("lh_data", ld_data, 32'hFFFF_8001);
      tick();

      // SH to DMEM upper half
      issue(1'b1, 32'h0000_0006, 32'h0000_BEEF, 3'b000, 2'b10);
      check("sh_wren", {31'b0, mem_wren}, 32'd1);
      check("sh_rden", {31'b0, mem_rden}, 32'd0);
      check("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
      check("sh_be", {28'b0, mem_be}, 32'hC);
      check("sh_addr", mem_addr, 32'h0000_0004);
      tick();
      check("sh_wren_held", {31'b0, mem_wren}, 32'd1);
      check("sh_wdata_held", mem_wdata, 32'hBEEF_BEEF);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      check_resp("sh_done", 1'b0, 2'b00);
      check("sh_wren_drop", {31'b0, mem_wren}, 32'd0);
      check("sh_ld_keep", ld_data, 32'hFFFF_8001);
      tick();

      // Error classes
      issue(1'b0, 32'h0000_0003, 32'h0, 3'b010, 2'b00);
      check_resp("lh_mis", 1'b1, 2'b01);
      check("lh_mis_strobe", {30'b0, mem_wren, mem_rden}, 32'd0);
      check("lh_mis_ld_keep", ld_data, 32'hFFFF_8001);
      tick();
      issue(1'b0, 32'h0000_5000, 32'h0, 3'b000, 2'b00);
      check_resp("ld_unmapped", 1'b1, 2'b10);
      tick();
      issue(1'b1, 32'h0000_7800, 32'h1111_1111, 3'b000, 2'b11);
      check_resp("sw_inwin", 1'b1, 2'b10);
      tick();
      issue(1'b1, 32'h0000_7000, 32'h2222_2222, 3'b000, 2'b00);
      check_resp("st_illegal", 1'b1, 2'b10);
      check("st_illegal_oreg0", oreg(0), 32'd0);
      tick();
      issue(1'b1, 32'h0000_7002, 32'h3333_3333, 3'b000, 2'b11);
      check_resp("sw_mis_prio", 1'b1, 2'b01);
      tick();
      issue(1'b0, 32'h0000_7020, 32'h0, 3'b000, 2'b00);
      check_resp("ld_past_out", 1'b1, 2'b10);
      tick();

      // Ack outside MEM is ignored
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      check("stray_ack", {30'b0, busy, ack}, 32'd0);

      // Input window and a full-word output register
      io_sw = 32'hCAFE_F00D; io_btn = 4'hA;
      issue(1'b0, 32'h0000_7800, 32'h0, 3'b000, 2'b00);
      check_resp("lw_sw", 1'b0, 2'b00);
      check("lw_sw_data", ld_data, 32'hCAFE_F00D);
      tick();
      issue(1'b0, 32'h0000_7804, 32'h0, 3'b000, 2'b00);
      check("lw_btn_data", ld_data, 32'h0000_000A);
      tick();
      issue(1'b0, 32'h0000_7802, 32'h0, 3'b100, 2'b00);
      check("lhu_sw_data", ld_data, 32'h0000_CAFE);
      tick();
      issue(1'b1, 32'h0000_701C, 32'hDEAD_BEEF, 3'b000, 2'b11);
      check("sw_oreg7", oreg(7), 32'hDEAD_BEEF);
      check("sw_oreg1_keep", oreg(1), 32'h0000_AB00);
      tick();
      issue(1'b0, 32'h0000_701C, 32'h0, 3'b111, 2'b00);
      check("lw_oreg7_data", ld_data, 32'hDEAD_BEEF);
      tick();

      // Timeout: no ack at all
      issue(1'b0, 32'h0000_0200, 32'h0, 3'b000, 2'b00);
      n_strobe = 0;
      for (int i = 0; i < 300 && !ack; i++) begin
         if (mem_rden) n_strobe++;
         tick();
      end
      check("tmo_rden_cycles", n_strobe, 32'd255);
      check_resp("tmo", 1'b1, 2'b11);
      check("tmo_rden_drop", {31'b0, mem_rden}, 32'd0);
      check("tmo_ld_keep", ld_data, 32'hDEAD_BEEF);
      tick();

      // Reset in the middle of a memory access
      issue(1'b0, 32'h0000_0300, 32'h0, 3'b000, 2'b00);
      tick();
      check("abort_rden_pre", {31'b0, mem_rden}, 32'd1);
      rst = 1'b0;
      tick();
      check("abort_strobe", {30'b0, mem_wren, mem_rden}, 32'd0);
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_ack", {31'b0, ack}, 32'd0);
      check("abort_oreg7", oreg(7), 32'd0);
      rst = 1'b1;
      tick();
      check("abort_no_ack", {31'b0, ack}, 32'd0);
      issue(1'b0, 32'h0000_7800, 32'h0, 3'b000, 2'b00);
      check_resp("post_rst", 1'b0, 2'b00);
      check("post_rst_data", ld_data, 32'hCAFE_F00D);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
